tanh_exhaustive_eval_4bit: RTL and testbench

Self-checking evaluation stage for 4-bit approximate tanh circuits. On a start pulse it sweeps every 4-bit input code into a combinational (or pipelined) approximate-tanh instance, samples that instance's 4-bit output, and compares it against an internal exact golden table. It accumulates error statistics and presents them after a done pulse. It sits directly around the activation circuit: upstream as stimulus source, downstream as result consumer.

---
 rtl/tanh_eval_pkg.sv | 26 ++
 rtl/tanh_golden_4bit.sv | 11 +
 rtl/tanh_exhaustive_eval_4bit.sv | 169 ++++++++++++++++
 tb/tb_tanh_exhaustive_eval_4bit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tanh_eval_pkg.sv
// Shared constants for the 4-bit tanh evaluation stage: golden table, widths, FSM encoding.
// The golden table is also consumed by the benches of the wider variants.
package tanh_eval_pkg;

    localparam int CODE_W    = 4;
    localparam int ERR_W     = 4;
    localparam int SQ_W      = 8;
    localparam int SUM_W     = 8;
    localparam int SQ_SUM_W  = 12;
    localparam int CNT_W     = 5;
    localparam int NUM_CODES = 16;

    // round(16 * tanh(x)) for x = code / 4, saturated at 15
    localparam logic [CODE_W-1:0] GOLDEN_TABLE [NUM_CODES] = '{
        4'd0,  4'd4,  4'd7,  4'd10, 4'd12, 4'd14, 4'd14, 4'd15,
        4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tanh_golden_4bit.sv
// Combinational golden lookup: Q2.2 input code to exact Q0.4 tanh value.
module tanh_golden_4bit
    import tanh_eval_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] golden
);

    assign golden = GOLDEN_TABLE[code];

endmodule

// File: rtl/tanh_exhaustive_eval_4bit.sv
// Sweeps all 16 input codes into an approximate-tanh circuit, compares each sample with
// the golden table and accumulates error statistics, reported with a one-cycle done pulse.
module tanh_exhaustive_eval_4bit
    import tanh_eval_pkg::*;
#(
    parameter int DUT_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [CODE_W-1:0]   dut_in,
    input  logic [CODE_W-1:0]   dut_out,
    output logic                busy,
    output logic                done,
    output logic [SUM_W-1:0]    err_sum,
    output logic [SQ_SUM_W-1:0] sq_sum,
    output logic [ERR_W-1:0]    err_max,
    output logic [CODE_W-1:0]   worst_in,
    output logic [CNT_W-1:0]    err_cnt,
    output state_t              fsm_state
);

    // Handshake: start is a single-cycle request with no ready; it is taken only in
    // IDLE (busy=0, done=0) and dropped otherwise. busy covers SWEEP and DRAIN, and
    // done pulses for one cycle when the statistics have become final.

    state_t            state;
    state_t            state_next;
    logic              start_acc;
    logic [1:0]        drain_cnt;
    logic              sweep_valid;
    logic [CODE_W-1:0] tap_code;
    logic              tap_valid;
    logic [CODE_W-1:0] tap_golden;

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [CODE_W-1:0] s1_golden;
    logic [CODE_W-1:0] s1_out;
    logic [ERR_W-1:0]  abs_err;
    logic [SQ_W-1:0]   sq_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_acc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SWEEP;
                    start_acc  = 1'b1;
                end
            end
            S_SWEEP: begin
                if (dut_in == CODE_W'(NUM_CODES - 1)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 2'(DUT_LAT)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy        = (state == S_SWEEP) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign fsm_state   = state;
    assign sweep_valid = (state == S_SWEEP);

    // Code wraps to 0 after 15, which is also the idle value
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in    <= '0;
            drain_cnt <= '0;
        end else begin
            dut_in    <= (state == S_SWEEP) ? dut_in + 1'b1 : '0;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    // Code/valid delay line matching the evaluated circuit's latency
    generate
        if (DUT_LAT == 0) begin : g_no_delay
            assign tap_code  = dut_in;
            assign tap_valid = sweep_valid;
        end else begin : g_delay
            logic [DUT_LAT*CODE_W-1:0] code_pipe;
            logic [DUT_LAT-1:0]        valid_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    code_pipe  <= '0;
                    valid_pipe <= '0;
                end else begin
                    code_pipe[CODE_W-1:0] <= dut_in;
                    valid_pipe[0]         <= sweep_valid;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        code_pipe[i*CODE_W +: CODE_W] <= code_pipe[(i-1)*CODE_W +: CODE_W];
                        valid_pipe[i]                 <= valid_pipe[i-1];
                    end
                end
            end

            assign tap_code  = code_pipe[(DUT_LAT-1)*CODE_W +: CODE_W];
            assign tap_valid = valid_pipe[DUT_LAT-1];
        end
    endgenerate

    tanh_golden_4bit u_golden (
        .code   (tap_code),
        .golden (tap_golden)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_code   <= '0;
            s1_golden <= '0;
            s1_out    <= '0;
        end else begin
            s1_valid  <= tap_valid;
            s1_code   <= tap_code;
            s1_golden <= tap_golden;
            s1_out    <= dut_out;
        end
    end

    always_comb begin
        abs_err = (s1_golden >= s1_out) ? s1_golden - s1_out : s1_out - s1_golden;
        sq_err  = SQ_W'(abs_err) * SQ_W'(abs_err);
    end

    // Strict greater-than keeps the earliest code among equal maxima
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            err_sum  <= '0;
            sq_sum   <= '0;
            err_max  <= '0;
            worst_in <= '0;
            err_cnt  <= '0;
        end else if (s1_valid) begin
            err_sum <= err_sum + SUM_W'(abs_err);
            sq_sum  <= sq_sum + SQ_SUM_W'(sq_err);
            if (abs_err != '0) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (abs_err > err_max) begin
                err_max  <= abs_err;
                worst_in <= s1_code;
            end
        end
    end

endmodule

// File: tb/tb_tanh_exhaustive_eval_4bit.sv
// Directed bench: a zero-latency instance driven by selectable circuit models and a
// two-cycle-latency instance driven by a delayed golden table.
module tb_tanh_exhaustive_eval_4bit;
    import tanh_eval_pkg::*;

    logic        clk;
    logic        rst;
    logic        start0, start2;
    logic [3:0]  dut_in0, dut_in2;
    logic [3:0]  dut_out0, dut_out2;
    logic        busy0, busy2, done0, done2;
    logic [7:0]  err_sum0, err_sum2;
    logic [11:0] sq_sum0, sq_sum2;
    logic [3:0]  err_max0, err_max2;
    logic [3:0]  worst_in0, worst_in2;
    logic [4:0]  err_cnt0, err_cnt2;
    state_t      fsm_state0, fsm_state2;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0: exact, 1: stuck at 0, 2: code 5 answers 10

    logic [3:0] gold_tb [16] = '{4'd0, 4'd4, 4'd7, 4'd10, 4'd12, 4'd14, 4'd14, 4'd15,
                                 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    logic [3:0] lat_d1, lat_d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tanh_exhaustive_eval_4bit #(.DUT_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
        .busy(busy0), .done(done0), .err_sum(err_sum0), .sq_sum(sq_sum0),
        .err_max(err_max0), .worst_in(worst_in0), .err_cnt(err_cnt0), .fsm_state(fsm_state0)
    );

    tanh_exhaustive_eval_4bit #(.DUT_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
        .busy(busy2), .done(done2), .err_sum(err_sum2), .sq_sum(sq_sum2),
        .err_max(err_max2), .worst_in(worst_in2), .err_cnt(err_cnt2), .fsm_state(fsm_state2)
    );

    always_comb begin
        case (mode)
            1:       dut_out0 = 4'd0;
            2:       dut_out0 = (dut_in0 == 4'd5) ? 4'd10 : gold_tb[dut_in0];
            default: dut_out0 = gold_tb[dut_in0];
        endcase
    end

    // Two-cycle pipelined model of an exact circuit
    always @(posedge clk) begin
        lat_d1 <= gold_tb[dut_in2];
        lat_d2 <= lat_d1;
    end
    assign dut_out2 = lat_d2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stats0(input string tag, input int e_sum, input int e_sq,
                                input int e_max, input int e_worst, input int e_cnt);
        check({tag, " err_sum"},  32'(err_sum0),  e_sum);
        check({tag, " sq_sum"},   32'(sq_sum0),   e_sq);
        check({tag, " err_max"},  32'(err_max0),  e_max);
        check({tag, " worst_in"}, 32'(worst_in0), e_worst);
        check({tag, " err_cnt"},  32'(err_cnt0),  e_cnt);
    endtask

    // Start in cycle 0, then run 45 cycles; pulse_a/pulse_b re-raise start in those cycles
    task automatic run(input bit use_lat2, input int pulse_a, input int pulse_b,
                       output int first_done, output int n_done, output int busy_c1,
                       output int din_c1, output int din_c6, output int din_c17);
        first_done = -1;
        n_done = 0;
        busy_c1 = 0;
        din_c1 = -1;
        din_c6 = -1;
        din_c17 = -1;
        if (use_lat2) start2 = 1'b1; else start0 = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            step();
            start0 = 1'b0;
            start2 = 1'b0;
            if (cyc == pulse_a || cyc == pulse_b) begin
                if (use_lat2) start2 = 1'b1; else start0 = 1'b1;
            end
            if (cyc == 1)  begin busy_c1 = use_lat2 ? int'(busy2) : int'(busy0);
                                 din_c1 = use_lat2 ? int'(dut_in2) : int'(dut_in0); end
            if (cyc == 6)  din_c6  = use_lat2 ? int'(dut_in2) : int'(dut_in0);
            if (cyc == 17) din_c17 = use_lat2 ? int'(dut_in2) : int'(dut_in0);
            if (use_lat2 ? done2 : done0) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
            end
        end
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    int first_done, n_done, busy_c1, din_c1, din_c6, din_c17, late_done;

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        step();
        step();
        check("rst busy0", 32'(busy0), 0);
        check("rst done0", 32'(done0), 0);
        check("rst dut_in0", 32'(dut_in0), 0);
        check("rst state0", 32'(fsm_state0), 32'(S_IDLE));
        check_stats0("rst", 0, 0, 0, 0, 0);
        check("rst busy2", 32'(busy2), 0);
        check("rst err_sum2", 32'(err_sum2), 0);
        rst = 1'b0;
        step();

        // Exact circuit, zero latency
        mode = 0;
        run(1'b0, -1, -1, first_done, n_done, busy_c1, din_c1, din_c6, din_c17);
        check("exact done cycle", first_done, 18);
        check("exact done count", n_done, 1);
        check("exact busy c1", busy_c1, 1);
        check("exact dut_in c1", din_c1, 0);
        check("exact dut_in c6", din_c6, 5);
        check("exact dut_in c17", din_c17, 0);
        check_stats0("exact", 0, 0, 0, 0, 0);
        check("exact idle busy", 32'(busy0), 0);
        check("exact idle state", 32'(fsm_state0), 32'(S_IDLE));

        // Output stuck at zero
        mode = 1;
        run(1'b0, -1, -1, first_done, n_done, busy_c1, din_c1, din_c6, din_c17);
        check("zero done cycle", first_done, 18);
        check_stats0("zero", 196, 2726, 15, 7, 15);

        // Single wrong code
        mode = 2;
        run(1'b0, -1, -1, first_done, n_done, busy_c1, din_c1, din_c6, din_c17);
        check_stats0("code5", 4, 16, 4, 5, 1);

        // Pipelined exact circuit
        run(1'b1, -1, -1, first_done, n_done, busy_c1, din_c1, din_c6, din_c17);
        check("lat2 done cycle", first_done, 20);
        check("lat2 done count", n_done, 1);
        check("lat2 dut_in c6", din_c6, 5);
        check("lat2 err_sum", 32'(err_sum2), 0);
        check("lat2 sq_sum", 32'(sq_sum2), 0);
        check("lat2 err_max", 32'(err_max2), 0);
        check("lat2 err_cnt", 32'(err_cnt2), 0);
        check_stats0("hold", 4, 16, 4, 5, 1);

        // Extra start pulses while busy and in the done cycle
        mode = 1;
        run(1'b0, 5, 18, first_done, n_done, busy_c1, din_c1, din_c6, din_c17);
        check("restart done cycle", first_done, 18);
        check("restart done count", n_done, 1);
        check_stats0("restart", 196, 2726, 15, 7, 15);

        // Reset in cycle 8 of a sweep
        mode = 2;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", 32'(busy0), 0);
        check("abort done", 32'(done0), 0);
        check("abort dut_in", 32'(dut_in0), 0);
        check("abort state", 32'(fsm_state0), 32'(S_IDLE));
        check_stats0("abort", 0, 0, 0, 0, 0);
        late_done = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done0) late_done++;
        end
        check("abort no done", late_done, 0);
        run(1'b0, -1, -1, first_done, n_done, busy_c1, din_c1, din_c6, din_c17);
        check("rerun done cycle", first_done, 18);
        check_stats0("rerun", 4, 16, 4, 5, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
